data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache sitting between the 8-bit CPU's load/store port and the word-wide data memory. It serves byte reads and writes from an 8-line × 4-byte array in one cycle on a hit. On a miss it stalls the CPU with BUSYWAIT, writes back a dirty victim, then refills the line from memory.

---
 rtl/data_cache.sv | 135 +++++++++++++
 tb/tb_data_cache.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate byte cache, 8 lines x 4 bytes (optional CACHE_STATS_EN counters)
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    typedef enum logic [1:0] {IDLE, WBACK, FETCH, UPDATE} state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];

    // High during the issue cycle of WBACK/FETCH, where MEM_BUSYWAIT is not trusted.
    logic        mem_first;
    // High in the IDLE cycle right after a refill, so the retried access is not a fresh hit.
    logic        retry;

    logic [2:0]  addr_tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        req;
    logic        hit;
    logic        mem_done;

    assign addr_tag = ADDRESS[7:5];
    assign idx      = ADDRESS[4:2];
    assign off      = ADDRESS[1:0];
    assign req      = READ | WRITE;
    assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign mem_done = !mem_first && !MEM_BUSYWAIT;
    assign READDATA = data_q[idx][{off, 3'b000} +: 8];

    // Next-state and memory-side outputs.
    always_comb begin
        state_next    = state;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'd0;
        MEM_WRITEDATA = 32'd0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    BUSYWAIT   = 1'b1;
                    state_next = (valid_q[idx] && dirty_q[idx]) ? WBACK : FETCH;
                end
            end
            WBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = data_q[idx];
                if (mem_done) state_next = FETCH;
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
                if (mem_done) state_next = UPDATE;
            end
            UPDATE: begin
                BUSYWAIT   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, line storage updates and issue-cycle tracking.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            mem_first <= 1'b0;
            retry     <= 1'b0;
            valid_q   <= 8'd0;
            dirty_q   <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                tag_q[i]  <= 3'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            state     <= state_next;
            mem_first <= (state_next != state) &&
                         ((state_next == WBACK) || (state_next == FETCH));
            retry     <= (state == UPDATE);
            if ((state == IDLE) && WRITE && hit) begin
                data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                dirty_q[idx]                    <= 1'b1;
            end
            if (state == UPDATE) begin
                data_q[idx]  <= MEM_READDATA;
                tag_q[idx]   <= addr_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters; a post-refill retry is not a hit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= 16'd0;
            MISS_COUNT <= 16'd0;
        end else if (state == IDLE && req) begin
            if (hit && !retry && HIT_COUNT != 16'hFFFF)
                HIT_COUNT <= HIT_COUNT + 16'd1;
            if (!hit && MISS_COUNT != 16'hFFFF)
                MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache against a transparent-memory model
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'd0;
    logic [7:0]  WRITEDATA = 8'd0;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef CACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef CACHE_STATS_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Backing memory: 64 blocks, fixed latency, logs each transaction's start.
    logic [31:0] mem [64];
    int          lat = 5;
    int          rd_n = 0;
    int          wr_n = 0;
    logic [5:0]  last_rd_addr = 6'd0;
    logic [5:0]  last_wr_addr = 6'd0;
    logic [31:0] last_wr_data = 32'd0;

    initial begin
        int         cnt;
        logic [1:0] kind;
        logic [1:0] prev;
        for (int i = 0; i < 64; i++)
            mem[i] = {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)} ^ 32'h5A5A5A5A;
        mem[9]    = 32'h44332211;
        mem[6'h3C] = 32'hDDCCBBAA;
        MEM_READDATA = 32'd0;
        MEM_BUSYWAIT = 1'b0;
        cnt  = 0;
        prev = 2'b00;
        forever begin
            @(negedge CLK);
            kind = {MEM_READ, MEM_WRITE};
            if (kind == 2'b00) cnt = 0;
            else if (kind != prev) begin
                cnt = 1;
                if (MEM_READ) begin rd_n++; last_rd_addr = MEM_ADDRESS; end
                else begin wr_n++; last_wr_addr = MEM_ADDRESS; last_wr_data = MEM_WRITEDATA; end
            end else cnt++;
            prev = kind;
            if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
            if (MEM_READ) MEM_READDATA = mem[MEM_ADDRESS];
            MEM_BUSYWAIT = (kind != 2'b00) && (cnt < lat);
        end
    end

    // Model: byte-level view the CPU should see, plus which block each index holds.
    logic [7:0] model_mem [256];
    logic       mv [8];
    logic       md [8];
    logic [2:0] mt [8];
    int         m_hits = 0;
    int         m_misses = 0;

    task automatic model_reset();
        for (int b = 0; b < 256; b++) model_mem[b] = mem[b/4][(b%4)*8 +: 8];
        for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 3'd0; end
        m_hits = 0;
        m_misses = 0;
    endtask

    function automatic logic [31:0] model_block(input logic [5:0] blk);
        return {model_mem[{blk, 2'd3}], model_mem[{blk, 2'd2}],
                model_mem[{blk, 2'd1}], model_mem[{blk, 2'd0}]};
    endfunction

    // Per-cycle compare: outside stalls the memory port is quiet and loads see the model.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (!RESET && !BUSYWAIT) begin
                chk("mem_port_quiet", {MEM_READ, MEM_WRITE, MEM_ADDRESS, 24'd0} | (MEM_WRITEDATA != 0),
                    32'd0);
                if (READ) chk("readdata", {24'd0, READDATA}, {24'd0, model_mem[ADDRESS]});
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        model_reset();
    endtask

    task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rdata, output int busy);
        int         rd0;
        int         wr0;
        int         nf;
        logic [2:0] i;
        logic       miss;
        logic       wb;
        i    = a[4:2];
        miss = !(mv[i] && mt[i] == a[7:5]);
        wb   = miss && mv[i] && md[i];
        nf   = (lat < 2) ? 2 : lat;
        @(negedge CLK);
        rd0 = rd_n; wr0 = wr_n;
        ADDRESS = a; WRITEDATA = d; READ = !wr; WRITE = wr;
        #1;
        busy = 0;
        while (BUSYWAIT && busy < 200) begin
            busy++;
            @(negedge CLK);
            #1;
        end
        if (BUSYWAIT) $display("FAIL busy_timeout actual=%0d required=<200", busy);
        rdata = READDATA;
        chk("busy_cycles", busy, miss ? (2 + nf + (wb ? nf : 0)) : 0);
        chk("fetch_count", rd_n - rd0, miss ? 1 : 0);
        chk("wback_count", wr_n - wr0, wb ? 1 : 0);
        if (miss) chk("fetch_addr", {26'd0, last_rd_addr}, {26'd0, a[7:2]});
        if (wb) begin
            chk("wback_addr", {26'd0, last_wr_addr}, {26'd0, mt[i], i});
            chk("wback_data", last_wr_data, model_block({mt[i], i}));
        end
        @(posedge CLK);
        #1 READ = 1'b0; WRITE = 1'b0;
        if (miss) begin mv[i] = 1'b1; mt[i] = a[7:5]; md[i] = 1'b0; m_misses++; end
        else m_hits++;
        if (wr) begin model_mem[a] = d; md[i] = 1'b1; end
    endtask

    initial begin
        logic [7:0] rd;
        int         busy;
        #1;
        do_reset();
        @(negedge CLK); #1;
        chk("rst_readdata", {24'd0, READDATA}, 32'h0);
        chk("rst_busywait", {31'd0, BUSYWAIT}, 32'h0);
        chk("rst_mem", {MEM_READ, MEM_WRITE, MEM_ADDRESS} | (MEM_WRITEDATA != 0), 32'h0);

        lat = 5;
        access(1'b0, 8'h25, 8'h00, rd, busy);
        chk("cold_read_data", {24'd0, rd}, 32'h22);
        chk("cold_read_busy", busy, 7);
        chk("cold_read_addr", {26'd0, last_rd_addr}, 32'h09);

        access(1'b0, 8'h27, 8'h00, rd, busy);
        chk("hit_read_data", {24'd0, rd}, 32'h44);
        chk("hit_read_busy", busy, 0);

        access(1'b1, 8'h24, 8'hAB, rd, busy);
        chk("write_hit_busy", busy, 0);

        lat = 3;
        access(1'b0, 8'h44, 8'h00, rd, busy);
        chk("evict_wb_addr", {26'd0, last_wr_addr}, 32'h09);
        chk("evict_wb_data", last_wr_data, 32'h443322AB);
        chk("evict_fetch_addr", {26'd0, last_rd_addr}, 32'h11);
        chk("evict_busy", busy, 8);

        lat = 4;
        access(1'b1, 8'hF0, 8'h5A, rd, busy);
        chk("wmiss_fetch_addr", {26'd0, last_rd_addr}, 32'h3C);
        chk("wmiss_busy", busy, 6);
        access(1'b0, 8'hF0, 8'h00, rd, busy);
        chk("wmiss_readback", {24'd0, rd}, 32'h5A);

        lat = 1;
        access(1'b0, 8'h10, 8'h00, rd, busy);
        chk("min_lat_wb_data", last_wr_data, 32'hDDCCBB5A);
        chk("min_lat_busy", busy, 6);
        access(1'b0, 8'h81, 8'h00, rd, busy);
        access(1'b1, 8'h13, 8'h77, rd, busy);
        access(1'b0, 8'h13, 8'h00, rd, busy);
        chk("store_load_13", {24'd0, rd}, 32'h77);

`ifdef CACHE_STATS_EN
        chk("hit_count", {16'd0, HIT_COUNT}, m_hits);
        chk("miss_count", {16'd0, MISS_COUNT}, m_misses);
`endif

        lat = 5;
        do_reset();
        @(negedge CLK);
        ADDRESS = 8'h25; READ = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        chk("midfill_mem_read_before", {31'd0, MEM_READ}, 32'h1);
        RESET = 1'b1; READ = 1'b0;
        @(posedge CLK);
        @(negedge CLK); #1;
        chk("midfill_mem_read_after", {31'd0, MEM_READ}, 32'h0);
        chk("midfill_busywait_after", {31'd0, BUSYWAIT}, 32'h0);
        RESET = 1'b0;
        model_reset();
        access(1'b0, 8'h25, 8'h00, rd, busy);
        chk("midfill_remiss_busy", busy, 7);
        chk("midfill_remiss_data", {24'd0, rd}, 32'h22);

`ifdef CACHE_STATS_EN
        chk("post_rst_miss_count", {16'd0, MISS_COUNT}, 32'h1);
        @(negedge CLK);
        force dut.HIT_COUNT = 16'hFFFF;
        #1 release dut.HIT_COUNT;
        access(1'b0, 8'h25, 8'h00, rd, busy);
        chk("hit_count_saturate", {16'd0, HIT_COUNT}, 32'hFFFF);
`endif

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
